// File: rtl/alu32_bist.sv
// Self-test controller for alu32: drives LFSR operands and op selects, compacts the ALU
// responses into a 32-bit MISR and compares the final signature against a golden value.
module alu32_bist #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned NUM_OPS     = 4,
    parameter int unsigned ALU_LAT     = 1,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  sel,
    input  logic [31:0] alu_out,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [15:0] vec_count
);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StCmp, StDone} state_t;

    localparam logic [15:0] LastVec   = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] LastDrain = 16'(ALU_LAT - 1);
    localparam logic [3:0]  LastOp    = 4'(NUM_OPS - 1);

    state_t             state;
    logic [31:0]        lfsr;
    logic [31:0]        lfsr_next;
    logic [31:0]        misr_next;
    logic [15:0]        drain_cnt;
    logic [ALU_LAT-1:0] valid_pipe;
    logic [ALU_LAT:0]   valid_shift;
    logic               issue;

    function automatic logic [31:0] mix_b(input logic [31:0] l);
        return {l[15:0], l[31:16]} ^ 32'h5555_5555;
    endfunction

    assign lfsr_next   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign misr_next   = {signature[30:0],
                          signature[31] ^ signature[21] ^ signature[1] ^ signature[0]}
                         ^ alu_out ^ {31'b0, alu_overflow};
    assign issue       = (state == StRun);
    assign valid_shift = {valid_pipe, issue};

    // Tags each issued vector so its response is compacted exactly ALU_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= valid_shift[ALU_LAT-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            lfsr      <= LFSR_SEED;
            a         <= '0;
            b         <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
            vec_count <= '0;
            drain_cnt <= '0;
        end else begin
            if (valid_pipe[ALU_LAT-1]) begin
                signature <= misr_next;
            end
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state     <= StRun;
                        lfsr      <= LFSR_SEED;
                        a         <= LFSR_SEED;
                        b         <= mix_b(LFSR_SEED);
                        sel       <= '0;
                        vec_count <= '0;
                        signature <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                StRun: begin
                    lfsr      <= lfsr_next;
                    vec_count <= vec_count + 16'd1;
                    if (vec_count == LastVec) begin
                        state     <= StDrain;
                        drain_cnt <= '0;
                        a         <= '0;
                        b         <= '0;
                        sel       <= '0;
                    end else begin
                        a   <= lfsr_next;
                        b   <= mix_b(lfsr_next);
                        sel <= (sel == LastOp) ? 4'd0 : sel + 4'd1;
                    end
                end
                StDrain: begin
                    if (drain_cnt == LastDrain) begin
                        state <= StCmp;
                    end else begin
                        drain_cnt <= drain_cnt + 16'd1;
                    end
                end
                StCmp: begin
                    state <= StDone;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (signature == GOLDEN_SIG);
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_bist.sv
// Bench for alu32_bist: a 1-cycle and a 3-cycle ALU stand-in, each with its own BIST, checked
// every cycle against a cycle-indexed model of the expected outputs.
module tb_alu32_bist;

    localparam int NV = 256;
    localparam int NO = 4;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] l);
        return {l[15:0], l[31:16]} ^ 32'h5555_5555;
    endfunction

    // {overflow, result}: add, sub, and, or; anything else xor
    function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] s);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (s)
            4'd0: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
            4'd1: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            default: r = x ^ y;
        endcase
        return {v, r};
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [32:0] resp);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ resp[31:0] ^ {31'b0, resp[32]};
    endfunction

    function automatic logic [31:0] sig_after(input int n, input bit flt);
        logic [31:0] l;
        logic [31:0] s;
        logic [32:0] r;
        l = SEED;
        s = 32'h0;
        for (int k = 0; k < n; k++) begin
            r = alu_fn(l, mix(l), 4'(k % NO));
            if (flt) r[0] = 1'b1;
            s = misr(s, r);
            l = lfsr_step(l);
        end
        return s;
    endfunction

    localparam logic [31:0] GOLDEN = sig_after(NV, 1'b0);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic fault = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a1, b1, out1, sig1, a3, b3, out3, sig3;
    logic [3:0]  sel1, sel3;
    logic        ovf1, ovf3, busy1, busy3, done1, done3, pass1, pass3;
    logic [15:0] vc1, vc3;
    logic [32:0] p1;
    logic [32:0] p3 [3];

    always @(posedge clk) begin
        p1    <= alu_fn(a1, b1, sel1);
        p3[0] <= alu_fn(a3, b3, sel3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign out1 = p1[31:0] | {31'b0, fault};
    assign ovf1 = p1[32];
    assign out3 = p3[2][31:0];
    assign ovf3 = p3[2][32];

    alu32_bist #(.NUM_VECTORS(NV), .NUM_OPS(NO), .ALU_LAT(1), .LFSR_SEED(SEED),
                 .GOLDEN_SIG(GOLDEN)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .sel(sel1),
        .alu_out(out1), .alu_overflow(ovf1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1), .vec_count(vc1));

    alu32_bist #(.NUM_VECTORS(NV), .NUM_OPS(NO), .ALU_LAT(3), .LFSR_SEED(SEED),
                 .GOLDEN_SIG(GOLDEN)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a3), .b(b3), .sel(sel3),
        .alu_out(out3), .alu_overflow(ovf3), .busy(busy3), .done(done3), .pass(pass3),
        .signature(sig3), .vec_count(vc3));

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected-value tables: vector states and signature after j compacted responses
    logic [31:0] lfsr_tab [NV];
    logic [31:0] sig_ok [NV+1];
    logic [31:0] sig_flt [NV+1];

    initial begin
        logic [31:0] l;
        l = SEED;
        for (int k = 0; k < NV; k++) begin
            lfsr_tab[k] = l;
            l = lfsr_step(l);
        end
        sig_ok[0] = 32'h0;
        sig_flt[0] = 32'h0;
        for (int k = 0; k < NV; k++) begin
            sig_ok[k+1]  = misr(sig_ok[k], alu_fn(lfsr_tab[k], mix(lfsr_tab[k]), 4'(k % NO)));
            sig_flt[k+1] = misr(sig_flt[k],
                                alu_fn(lfsr_tab[k], mix(lfsr_tab[k]), 4'(k % NO)) | 33'd1);
        end
    end

    // Model state: -1 after reset with no run, else the cycle number since the start edge
    int cyc1 = -1;
    int cyc3 = -1;
    bit flt1 = 1'b0;

    function automatic int next_cyc(input int c, input int lat, input logic st);
        if (st && (c == -1 || c >= NV + lat + 2)) return 1;
        if (c >= 1 && c < 1000000) return c + 1;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc1 <= -1;
            cyc3 <= -1;
        end else begin
            cyc1 <= next_cyc(cyc1, 1, start);
            cyc3 <= next_cyc(cyc3, 3, start);
            if (start && (cyc1 == -1 || cyc1 >= NV + 3)) flt1 <= fault;
        end
    end

    task automatic check_dut(input string tag, input int c, input int lat, input bit flt,
                             input logic [31:0] av, input logic [31:0] bv, input logic [3:0] sv,
                             input logic bsy, input logic dn, input logic ps,
                             input logic [31:0] sg, input logic [15:0] vc);
        logic [31:0] ea, eb, es, fin;
        logic [3:0]  esel;
        logic        ebusy, edone, epass;
        int          idx, evc;
        if (c < 1) begin
            ea = 0; eb = 0; esel = 0; ebusy = 0; edone = 0; epass = 0; es = 0; evc = 0;
        end else begin
            ea    = (c <= NV) ? lfsr_tab[c-1] : 32'h0;
            eb    = (c <= NV) ? mix(ea) : 32'h0;
            esel  = (c <= NV) ? 4'((c - 1) % NO) : 4'd0;
            ebusy = (c <= NV + lat + 1);
            edone = (c >= NV + lat + 2);
            idx   = c - lat - 1;
            if (idx < 0) idx = 0;
            if (idx > NV) idx = NV;
            es    = flt ? sig_flt[idx] : sig_ok[idx];
            fin   = flt ? sig_flt[NV] : sig_ok[NV];
            epass = edone && (fin == GOLDEN);
            evc   = (c - 1 > NV) ? NV : c - 1;
        end
        chk({tag, ".a"}, av, ea);
        chk({tag, ".b"}, bv, eb);
        chk({tag, ".sel"}, {28'b0, sv}, {28'b0, esel});
        chk({tag, ".busy"}, {31'b0, bsy}, {31'b0, ebusy});
        chk({tag, ".done"}, {31'b0, dn}, {31'b0, edone});
        chk({tag, ".pass"}, {31'b0, ps}, {31'b0, epass});
        chk({tag, ".signature"}, sg, es);
        chk({tag, ".vec_count"}, {16'b0, vc}, 32'(evc));
    endtask

    always @(negedge clk) begin
        check_dut("d1", cyc1, 1, flt1, a1, b1, sel1, busy1, done1, pass1, sig1, vc1);
        check_dut("d3", cyc3, 3, 1'b0, a3, b3, sel3, busy3, done3, pass3, sig3, vc3);
    end

    task automatic run_once(input bit poke, output int d1, output int d3);
        d1 = 0;
        d3 = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 275; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("cycle1.a", a1, 32'hACE1_2468);
                chk("cycle1.b", b1, 32'h713D_F9B4);
                chk("cycle1.sel", {28'b0, sel1}, 32'd0);
            end
            if (c == 2) begin
                chk("cycle2.a", a1, 32'h5670_9234);
                chk("cycle2.sel", {28'b0, sel1}, 32'd1);
            end
            if (c == 5) begin
                chk("cycle5.a", a1, 32'h8AEE_1245);
                chk("cycle5.sel", {28'b0, sel1}, 32'd0);
            end
            if (done1 && d1 == 0) d1 = c;
            if (done3 && d3 == 0) d3 = c;
            start = poke && (c == 50 || c == 257 || c == 258);
        end
        start = 1'b0;
    endtask

    initial begin
        int d1, d3;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            start = 1'($urandom);
        end
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("model.lfsr4", lfsr_tab[4], 32'h8AEE_1245);

        run_once(1'b1, d1, d3);
        chk("run1.done_cycle_lat1", 32'(d1), 32'd259);
        chk("run1.done_cycle_lat3", 32'(d3), 32'd261);
        chk("run1.pass_lat1", {31'b0, pass1}, 32'd1);
        chk("run1.pass_lat3", {31'b0, pass3}, 32'd1);
        chk("run1.sig_lat1", sig1, GOLDEN);
        chk("run1.sig_lat3", sig3, GOLDEN);

        run_once(1'b0, d1, d3);
        chk("restart.done_cycle", 32'(d1), 32'd259);
        chk("restart.sig", sig1, GOLDEN);
        chk("restart.pass", {31'b0, pass1}, 32'd1);

        fault = 1'b1;
        run_once(1'b0, d1, d3);
        fault = 1'b0;
        chk("stuck1.pass", {31'b0, pass1}, 32'd0);
        chk("stuck1.sig_differs", {31'b0, sig1 != GOLDEN}, 32'd1);
        chk("stuck1.other_pass", {31'b0, pass3}, 32'd1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.a", a1, 32'h0);
        chk("abort.b", b1, 32'h0);
        chk("abort.busy", {31'b0, busy1}, 32'd0);
        chk("abort.signature", sig1, 32'h0);
        chk("abort.vec_count", {16'b0, vc1}, 32'd0);
        chk("abort.busy_lat3", {31'b0, busy3}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run_once(1'b0, d1, d3);
        chk("after_abort.done_cycle", 32'(d1), 32'd259);
        chk("after_abort.pass", {31'b0, pass1}, 32'd1);
        chk("after_abort.sig", sig1, GOLDEN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
